mont_mult_seq: RTL and testbench

- Parametrised, bit-serial (radix-2) Montgomery multiplier; successor to the fixed 3-bit combinational Montgomery datapath.
- Runtime odd modulus m and caller-supplied r2 = R^2 mod m, where R = 2^WIDTH.
- mode 0 returns the raw Montgomery product a*b*R^-1 mod m. mode 1 chains two passes and returns the plain product a*b mod m.
- Used as a shared arithmetic engine behind a start/done handshake.

---
 rtl/mont_pkg.sv | 15 +
 rtl/mont_mult_seq_if.sv | 17 +
 rtl/mont_step.sv | 22 ++
 rtl/mont_mult_seq.sv | 135 +++++++++++++
 tb/tb_mont_mult_seq.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/mont_pkg.sv
// Shared types and constants for the bit-serial Montgomery multiplier.
package mont_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ITER1 = 3'd1,
        CORR1 = 3'd2,
        ITER2 = 3'd3,
        CORR2 = 3'd4
    } state_e;

    localparam logic MODE_MONT  = 1'b0;
    localparam logic MODE_PLAIN = 1'b1;

endpackage

// File: rtl/mont_mult_seq_if.sv
// Request/response bundle for the Montgomery multiplier: start/done handshake plus operands.
interface mont_mult_seq_if #(parameter int WIDTH = 8);

    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] r2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (output start, mode, a, b, m, r2, input busy, done, result);
    modport slave  (input start, mode, a, b, m, r2, output busy, done, result);

endinterface

// File: rtl/mont_step.sv
// One radix-2 Montgomery iteration: add y if the x bit is set, make even with m, halve.
module mont_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH+1:0] t_i,
    input  logic             x_bit_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH+1:0] t_o
);

    // One spare bit so illegal operands cannot wrap before the shift.
    logic [WIDTH+2:0] t1;
    logic [WIDTH+2:0] t2;

    always_comb begin
        t1  = {1'b0, t_i} + (x_bit_i ? {3'b000, y_i} : '0);
        t2  = t1 + (t1[0] ? {3'b000, m_i} : '0);
        t_o = (WIDTH+2)'(t2 >> 1);
    end

endmodule

// File: rtl/mont_mult_seq.sv
// Sequential Montgomery multiplier: one iteration per clock, optional second pass
// against R^2 mod m to return the plain modular product.
module mont_mult_seq
    import mont_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    mont_mult_seq_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   r2_q, r2_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               mode_q, mode_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [WIDTH+1:0]   t_q, t_d;
    logic [WIDTH+1:0]   t_step;
    logic [WIDTH+1:0]   t_corr;
    logic [WIDTH+1:0]   m_ext;

    mont_step #(.WIDTH(WIDTH)) u_step (
        .t_i     (t_q),
        .x_bit_i (x_q[0]),
        .y_i     (y_q),
        .m_i     (m_q),
        .t_o     (t_step)
    );

    // T < 2m holds after every pass, so one conditional subtract is enough.
    assign m_ext  = {2'b00, m_q};
    assign t_corr = (t_q >= m_ext) ? (t_q - m_ext) : t_q;

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = res_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        m_d     = m_q;
        r2_d    = r2_q;
        res_d   = res_q;
        mode_d  = mode_q;
        t_d     = t_q;
        done_d  = 1'b0;
        // busy trails the state by one edge so it spans exactly up to the done cycle
        busy_d  = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                // done_q marks the done cycle, where a new request is not yet taken
                if (bus.start && !done_q) begin
                    x_d     = bus.a;
                    y_d     = bus.b;
                    m_d     = bus.m;
                    r2_d    = bus.r2;
                    mode_d  = bus.mode;
                    t_d     = '0;
                    cnt_d   = '0;
                    state_d = ITER1;
                end
            end
            ITER1, ITER2: begin
                t_d   = t_step;
                x_d   = x_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = (state_q == ITER1) ? CORR1 : CORR2;
                end
            end
            CORR1: begin
                t_d = t_corr;
                if (mode_q == MODE_PLAIN) begin
                    x_d     = t_corr[WIDTH-1:0];
                    y_d     = r2_q;
                    t_d     = '0;
                    state_d = ITER2;
                end else begin
                    res_d   = t_corr[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            CORR2: begin
                t_d     = t_corr;
                res_d   = t_corr[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            m_q     <= '0;
            r2_q    <= '0;
            res_q   <= '0;
            mode_q  <= MODE_MONT;
            t_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            m_q     <= m_d;
            r2_q    <= r2_d;
            res_q   <= res_d;
            mode_q  <= mode_d;
            t_q     <= t_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_mont_mult_seq.sv
// Directed bench for mont_mult_seq at WIDTH 8, 3 and 16 with hand-computed and modelled results.
module tb_mont_mult_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mont_mult_seq_if #(.WIDTH(8))  i8 ();
    mont_mult_seq_if #(.WIDTH(3))  i3 ();
    mont_mult_seq_if #(.WIDTH(16)) i16 ();

    mont_mult_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(i8));
    mont_mult_seq #(.WIDTH(3))  dut3  (.clk(clk), .rst_n(rst_n), .bus(i3));
    mont_mult_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(i16));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Counts edges after the start edge until done; bc counts busy cycles seen.
    task automatic wait8(output int n, output int bc);
        n = 0; bc = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (i8.busy === 1'b1) bc++;
        end while (i8.done !== 1'b1 && n < 100);
    endtask

    task automatic start8(input logic md, input logic [7:0] a, input logic [7:0] b, input logic [7:0] r2);
        for (int k = 0; k < 4 && i8.done === 1'b1; k++) @(negedge clk);
        @(negedge clk);
        i8.mode = md; i8.a = a; i8.b = b; i8.m = 8'd251; i8.r2 = r2; i8.start = 1'b1;
        @(posedge clk); #2;
        i8.start = 1'b0; i8.a = ~a; i8.b = ~b; i8.r2 = ~r2; i8.m = 8'd13;
    endtask

    task automatic op8(input logic md, input logic [7:0] a, input logic [7:0] b, input logic [7:0] r2,
                       output logic [7:0] res, output int n, output int bc);
        start8(md, a, b, r2);
        wait8(n, bc);
        res = (i8.done === 1'b1) ? i8.result : 'x;
    endtask

    task automatic op3(input logic [2:0] a, input logic [2:0] b, output logic [2:0] res);
        int n;
        for (int k = 0; k < 4 && i3.done === 1'b1; k++) @(negedge clk);
        @(negedge clk);
        i3.mode = 1'b1; i3.a = a; i3.b = b; i3.m = 3'd7; i3.r2 = 3'd1; i3.start = 1'b1;
        @(posedge clk); #2;
        i3.start = 1'b0; i3.a = ~a; i3.b = ~b;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (i3.done !== 1'b1 && n < 50);
        res = (i3.done === 1'b1) ? i3.result : 'x;
    endtask

    task automatic op16(input logic md, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] m, input logic [15:0] r2, output logic [15:0] res);
        int n;
        for (int k = 0; k < 4 && i16.done === 1'b1; k++) @(negedge clk);
        @(negedge clk);
        i16.mode = md; i16.a = a; i16.b = b; i16.m = m; i16.r2 = r2; i16.start = 1'b1;
        @(posedge clk); #2;
        i16.start = 1'b0; i16.a = ~a; i16.b = ~b;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (i16.done !== 1'b1 && n < 100);
        res = (i16.done === 1'b1) ? i16.result : 'x;
    endtask

    logic [7:0]  res8;
    logic [2:0]  res3;
    logic [15:0] res16;
    logic [63:0] ma, aa, ba, r2a;
    int n, bc, dcnt;

    initial begin
        i8.start = 0;  i8.mode = 0;  i8.a = 0;  i8.b = 0;  i8.m = 8'd251; i8.r2 = 0;
        i3.start = 0;  i3.mode = 0;  i3.a = 0;  i3.b = 0;  i3.m = 3'd7;   i3.r2 = 0;
        i16.start = 0; i16.mode = 0; i16.a = 0; i16.b = 0; i16.m = 16'd3; i16.r2 = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy",   i8.busy, 0);
        chk("reset_done",   i8.done, 0);
        chk("reset_result", i8.result, 0);
        @(negedge clk) rst_n = 1'b1;

        // 5*7*256^-1 mod 251 = 35*201 mod 251 = 7
        op8(1'b0, 8'd5, 8'd7, 8'd0, res8, n, bc);
        chk("t1_result", res8, 7);
        chk("t1_latency", n, 9);
        chk("t1_busy_cycles", bc, 9);
        @(posedge clk); #1;
        chk("t1_done_one_cycle", i8.done, 0);
        chk("t1_busy_low_after", i8.busy, 0);

        op8(1'b1, 8'd10, 8'd20, 8'd25, res8, n, bc);
        chk("t2_result", res8, 200);
        chk("t2_latency", n, 18);

        op8(1'b1, 8'd250, 8'd250, 8'd25, res8, n, bc);
        chk("t3_250x250", res8, 1);
        op8(1'b1, 8'd0, 8'd123, 8'd25, res8, n, bc);
        chk("t3_0x123", res8, 0);

        // start held through the whole operation and the done cycle
        repeat (2) @(negedge clk);
        i8.mode = 1'b0; i8.a = 8'd5; i8.b = 8'd7; i8.m = 8'd251; i8.r2 = 8'd25; i8.start = 1'b1;
        @(posedge clk); #2;
        i8.mode = 1'b1; i8.a = 8'd10; i8.b = 8'd20;
        wait8(n, bc);
        chk("t4_first_result", i8.result, 7);
        chk("t4_first_latency", n, 9);
        @(posedge clk); #1;
        chk("t4_done_cycle_pulse", i8.done, 0);
        @(posedge clk); #2;
        i8.start = 1'b0;
        wait8(n, bc);
        chk("t4_second_result", i8.result, 200);
        chk("t4_second_latency", n, 18);

        // asynchronous reset while in the second pass
        start8(1'b1, 8'd10, 8'd20, 8'd25);
        repeat (12) @(posedge clk);
        #3;
        chk("t5_busy_before_reset", i8.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_busy_async", i8.busy, 0);
        chk("t5_done_async", i8.done, 0);
        chk("t5_result_async", i8.result, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        repeat (30) begin @(posedge clk); #1; if (i8.done === 1'b1) dcnt++; end
        chk("t5_no_spurious_done", dcnt, 0);
        op8(1'b1, 8'd100, 8'd3, 8'd25, res8, n, bc);
        chk("t5_after_reset_result", res8, 49);
        chk("t5_after_reset_latency", n, 18);

        // WIDTH=3 exhaustive plain product mod 7 (R=8, R^2 mod 7 = 1)
        for (int a = 0; a < 7; a++) begin
            for (int b = 0; b < 7; b++) begin
                op3(3'(a), 3'(b), res3);
                chk($sformatf("w3_%0dx%0d", a, b), res3, 64'((a * b) % 7));
            end
        end

        // WIDTH=16 random sweep against a 64-bit reference
        repeat (20) begin
            ma  = 64'($urandom_range(3, 65535) | 1);
            aa  = 64'($urandom) % ma;
            ba  = 64'($urandom) % ma;
            r2a = (64'h1_0000_0000) % ma;
            op16(1'b1, aa[15:0], ba[15:0], ma[15:0], r2a[15:0], res16);
            chk($sformatf("w16_plain_%0dx%0d_m%0d", aa, ba, ma), 64'(res16), (aa * ba) % ma);
            op16(1'b0, aa[15:0], ba[15:0], ma[15:0], r2a[15:0], res16);
            chk($sformatf("w16_mont_%0dx%0d_m%0d", aa, ba, ma), (64'(res16) << 16) % ma, (aa * ba) % ma);
            chk("w16_mont_below_m", 64'(64'(res16) < ma), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
